// File: rtl/dram_req_buffer.sv
// Per-bank L2 request queue: in-order, first-word-fall-through buffer between
// L2 request bursts and the DRAM address-translation/scheduling stage.
module dram_req_buffer #(
  parameter int L2_REQ_WIDTH = 22,
  parameter int DATA_WIDTH   = 1,
  parameter int DEPTH        = 4,
  parameter int AF_THRESH    = 3
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    flush,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [L2_REQ_WIDTH-1:0] req_addr,
  input  logic                    req_rw,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [L2_REQ_WIDTH-1:0] out_addr,
  output logic                    out_rw,
  output logic [DATA_WIDTH-1:0]   out_wdata,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full,
  output logic                    almost_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = L2_REQ_WIDTH + 1 + DATA_WIDTH;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic [EW-1:0] head;

  assign empty       = (count_q == '0);
  assign full        = (count_q == CW'(DEPTH));
  assign almost_full = (count_q >= CW'(AF_THRESH));
  assign count       = count_q;

  assign req_ready = !full && !flush;
  assign out_valid = !empty && !flush;

  // rst_b gating keeps storage untouched while reset holds the pointers.
  assign push = req_valid && req_ready && rst_b;
  assign pop  = out_valid && out_ready;

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    out_addr  = '0;
    out_rw    = 1'b0;
    out_wdata = '0;
    if (out_valid) begin
      {out_addr, out_rw, out_wdata} = head;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req_addr, req_rw, req_wdata};
    end
  end

endmodule

// File: doc/dram_req_buffer.md
Name: dram_req_buffer

Overview:
- Per-bank L2 request queue. One instance per bank, generated alongside the per-bank address translator in the DRAM controller top.
- Accepts L2 requests (address, read/write, write data) with a valid/ready handshake and holds them in order.
- Presents the oldest request first-word-fall-through to the downstream address-translation and scheduling stage.
- Decouples L2 request bursts from DRAM command timing.

Parameters:
- L2_REQ_WIDTH, 22, request address width: 13-bit address plus 9-bit offset.
- DATA_WIDTH, 1, write-data width.
- DEPTH, 4, number of entries. Must be a power of 2 and at least 2.
- AF_THRESH, 3, almost_full asserts when count >= AF_THRESH. Legal range 1..DEPTH.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_b  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all queued requests.
- req_valid  in  1  upstream request valid.
- req_ready  out  1  buffer can accept a request this cycle.
- req_addr  in  L2_REQ_WIDTH  request address {addr, offset}.
- req_rw  in  1  1 = write, 0 = read.
- req_wdata  in  DATA_WIDTH  write data; stored but ignored downstream for reads.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream consumes the head entry.
- out_addr  out  L2_REQ_WIDTH  head address.
- out_rw  out  1  head read/write.
- out_wdata  out  DATA_WIDTH  head write data.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AF_THRESH.

Behaviour:
- State: storage array [DEPTH], write pointer, read pointer ($clog2(DEPTH) bits each, natural wrap), count register.
- Reset (rst_b low, asynchronous):
  - Pointers and count are 0.
  - empty=1, full=0, almost_full=0 (for AF_THRESH>=1), out_valid=0.
  - out_addr, out_rw and out_wdata are 0.
  - Storage contents are not reset.
  - req_ready reads 1 during reset, but no push is performed while rst_b is low.
- Combinational outputs:
  - req_ready = !full && !flush.
  - out_valid = !empty && !flush.
  - out_* show storage[rd_ptr] when out_valid=1; otherwise 0.
- Push: req_valid && req_ready at the edge. Writes {req_addr, req_rw, req_wdata} to storage[wr_ptr]; wr_ptr increments, wrapping DEPTH-1 -> 0.
- Pop: out_valid && out_ready at the edge. rd_ptr increments with the same wrap.
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop in the same cycle: count unchanged, both pointers advance. Legal at any occupancy 1..DEPTH-1.
  - When full, req_ready=0, so no simultaneous push at full.
  - When empty, out_valid=0, so no pop at empty.
- Latency: a request pushed into an empty buffer appears on out_valid/out_* on the cycle after the accepting edge. There is no same-cycle bypass.
- Ordering: strict FIFO; no reordering or merging.
- Flush:
  - On the edge with flush=1, pointers and count go to 0.
  - Flush wins over any push or pop in the same cycle; neither handshake completes because both ready and valid are forced low.
  - The buffer is empty on the following cycle.
- Status flags empty, full and almost_full derive from the count register only; they do not depend on flush in the same cycle.
- Reset asserted mid-operation: all queued requests are discarded immediately; no partial entry survives.
- Sizing: count must hold DEPTH exactly, hence $clog2(DEPTH)+1 bits. The pointer width alone does not distinguish full from empty; the implementation uses count for that.

Test Plan:
- Reset and idle: assert rst_b=0 mid-simulation with 2 entries queued -> immediately count=0, empty=1, out_valid=0, out_addr=0. After release, req_ready=1.
- Fill to full (DEPTH=4): push addr 0x00001, 0x00002, 0x00003, 0x00004 with out_ready=0.
  - almost_full rises after the 3rd push.
  - After the 4th push: full=1, req_ready=0, count=4.
  - A 5th req_valid with addr 0x3FFFFF is not accepted.
- Drain order: from full, set out_ready=1 for 4 cycles -> out_addr sequence 0x00001..0x00004. Then empty=1, out_valid=0, count=0.
- Simultaneous push/pop: at count=2, drive push and pop for 10 consecutive cycles with incrementing addresses.
  - count stays 2 throughout.
  - Outputs appear in push order, crossing the pointer wrap at least twice.
- Empty latency: push addr 0x2A5 with rw=1, wdata=1 into an empty buffer -> out_valid=1 exactly one cycle later with out_addr=0x2A5, out_rw=1, out_wdata=1.
- Flush priority: at count=3, assert flush together with req_valid and out_ready.
  - In that cycle, req_ready=0 and out_valid=0.
  - Next cycle: count=0, and the flushed-cycle request is absent.
  - The next push afterwards emerges first.
